cpu_bus_bridge: RTL

//  Initiator side of the chip/CPU bus slot handshake: converts asynchronous 68000 bus cycles
//  (_AS/_UDS/_LDS/R_W) into single-clock-domain cpurd/cpuhwr/cpulwr requests with a latched address.

---
 rtl/cpu_bridge_pkg.sv | 18 +
 rtl/cpu_bus_bridge_if.sv | 33 +++
 rtl/cpu_sync.sv | 23 ++
 rtl/cpu_bus_bridge.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_bridge_pkg.sv
// Shared types for the 68000 -> chip bus bridge: FSM states, request bundle, timeout counter width.
package cpu_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  typedef struct packed {
    logic rd;
    logic hwr;
    logic lwr;
  } req_t;

  localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// Pin-level bundle between the 68000, the bridge and the chip-bus decoder/arbiter.
// master = the bridge itself, slave = the surrounding CPU pins and decoder.
interface cpu_bus_bridge_if;
  logic        cpu_as_n;
  logic        cpu_uds_n;
  logic        cpu_lds_n;
  logic        cpu_r_w;
  logic [22:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_doe;
  logic        cpu_dtack_n;
  logic        cpu_berr_n;
  logic [22:0] cpuaddress;
  logic        cpurd;
  logic        cpuhwr;
  logic        cpulwr;
  logic        cpuok;
  logic [15:0] bus_din;
  logic [15:0] bus_dout;

  modport master (
    input  cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_r_w, cpu_addr, cpu_din, cpuok, bus_din,
    output cpu_dout, cpu_doe, cpu_dtack_n, cpu_berr_n, cpuaddress, cpurd, cpuhwr, cpulwr,
           bus_dout
  );

  modport slave (
    output cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_r_w, cpu_addr, cpu_din, cpuok, bus_din,
    input  cpu_dout, cpu_doe, cpu_dtack_n, cpu_berr_n, cpuaddress, cpurd, cpuhwr, cpulwr,
           bus_dout
  );
endinterface

// File: rtl/cpu_sync.sv
// Two-flop synchronizer with a configurable asynchronous reset value.
module cpu_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/cpu_bus_bridge.sv
// 68000 bus cycle -> single-clock cpurd/cpuhwr/cpulwr request bridge with DTACK return.
// Optional `BRIDGE_TIMEOUT_EN: bus error after TIMEOUT_CYCLES ungranted ACCESS clocks.
module cpu_bus_bridge
  import cpu_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_bus_bridge_if.master  bus
);

  localparam int NSYNC = 4;
  // bit 3 = as, 2 = uds, 1 = lds, 0 = r_w; _AS resets asserted so a cycle straddling reset is ignored
  localparam logic [NSYNC-1:0] SYNC_RST = 4'b1000;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** TIMEOUT_CNT_W)) begin : g_bad_timeout
    $error("cpu_bus_bridge: TIMEOUT_CYCLES out of range");
  end

  logic [NSYNC-1:0] pin_a, pin_s;
  assign pin_a = {~bus.cpu_as_n, ~bus.cpu_uds_n, ~bus.cpu_lds_n, bus.cpu_r_w};

  for (genvar i = 0; i < NSYNC; i++) begin : g_sync
    cpu_sync #(.RST_VAL(SYNC_RST[i])) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pin_a[i]),
      .q       (pin_s[i])
    );
  end

  logic as_s, uds_s, lds_s, r_w_s;
  assign {as_s, uds_s, lds_s, r_w_s} = pin_s;

  state_e      state_q, state_d;
  logic        as_prev_q, as_prev_d;
  logic        pend_q, pend_d;
  req_t        req_q, req_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        dtack_n_q, dtack_n_d;
  logic        doe_q, doe_d;
`ifdef BRIDGE_TIMEOUT_EN
  logic                     berr_n_q, berr_n_d;
  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic as_edge, strb;
  assign as_edge = as_s & ~as_prev_q;
  assign strb    = uds_s | lds_s;

  always_comb begin
    state_d   = state_q;
    as_prev_d = as_s;
    pend_d    = pend_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    dtack_n_d = dtack_n_q;
    doe_d     = doe_q;
`ifdef BRIDGE_TIMEOUT_EN
    berr_n_d  = berr_n_q;
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // an _AS edge without data strobes (e.g. write or CPU space) is remembered until strobes appear
        if (!as_s)               pend_d = 1'b0;
        else if (as_edge && !strb) pend_d = 1'b1;
        if (as_s && (as_edge || pend_q) && strb) begin
          addr_d    = bus.cpu_addr;
          wdata_d   = bus.cpu_din;
          req_d.rd  = r_w_s;
          req_d.hwr = ~r_w_s & uds_s;
          req_d.lwr = ~r_w_s & lds_s;
          pend_d    = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
          cnt_d     = '0;
`endif
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!as_s) begin
          req_d   = '0;
          state_d = IDLE;
        end else if (bus.cpuok) begin
          if (req_q.rd) rdata_d = bus.bus_din;
          req_d     = '0;
          dtack_n_d = 1'b0;
          doe_d     = req_q.rd;
          state_d   = ACK;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d    = '0;
          berr_n_d = 1'b0;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK: begin
        if (!as_s) begin
          dtack_n_d = 1'b1;
          doe_d     = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
          berr_n_d  = 1'b1;
`endif
          state_d   = IDLE;
        end
      end
      default: begin
        req_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      as_prev_q <= 1'b1;
      pend_q    <= 1'b0;
      req_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dtack_n_q <= 1'b1;
      doe_q     <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      berr_n_q  <= 1'b1;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      as_prev_q <= as_prev_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      dtack_n_q <= dtack_n_d;
      doe_q     <= doe_d;
`ifdef BRIDGE_TIMEOUT_EN
      berr_n_q  <= berr_n_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.cpurd       = req_q.rd;
  assign bus.cpuhwr      = req_q.hwr;
  assign bus.cpulwr      = req_q.lwr;
  assign bus.cpuaddress  = addr_q;
  assign bus.bus_dout    = wdata_q;
  assign bus.cpu_dout    = rdata_q;
  assign bus.cpu_doe     = doe_q;
  assign bus.cpu_dtack_n = dtack_n_q;
`ifdef BRIDGE_TIMEOUT_EN
  assign bus.cpu_berr_n  = berr_n_q;
`else
  assign bus.cpu_berr_n  = 1'b1;
`endif

endmodule
